// File: rtl/gray_counter_decoder.sv
// ---------------------------------------------------------------------------
// gray_counter_decoder
//
// Purpose:
//   Receive-side monitor for a gray-coded up-counter in the same clock
//   domain. Each valid sample is converted to binary and compared with the
//   last accepted value. A +1 step is counted into a wider binary total.
//   Any other change raises a sticky error and resynchronises tracking.
//
// Ports:
//   clk_i     in   1          clock; all state updates on the rising edge
//   reset_i   in   1          synchronous active-high reset
//   valid_i   in   1          gray_i holds a sample to consume this cycle
//   gray_i    in   WIDTH      gray-coded count sample
//   clear_i   in   1          clears total_o/error_o and re-arms tracking
//   bin_o     out  WIDTH      binary value of the last accepted sample
//   step_o    out  1          one-cycle pulse: last sample was a legal +1 step
//   wrap_o    out  1          one-cycle pulse: that step went all-ones -> 0
//   total_o   out  ACC_WIDTH  legal steps since reset/clear, modulo 2^ACC_WIDTH
//   error_o   out  1          sticky: an illegal transition has been seen
//   locked_o  out  1          high while tracking (TRACK state)
// ---------------------------------------------------------------------------
module gray_counter_decoder #(
   parameter int WIDTH     = 3,
   parameter int ACC_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 valid_i,
   input  logic [WIDTH-1:0]     gray_i,
   input  logic                 clear_i,
   output logic [WIDTH-1:0]     bin_o,
   output logic                 step_o,
   output logic                 wrap_o,
   output logic [ACC_WIDTH-1:0] total_o,
   output logic                 error_o,
   output logic                 locked_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     bin_q, bin_d;
   logic                 step_q, step_d;
   logic                 wrap_q, wrap_d;
   logic [ACC_WIDTH-1:0] total_q, total_d;
   logic                 error_q, error_d;

   logic [WIDTH-1:0]     sample_bin;
   logic [WIDTH-1:0]     delta;

   // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
   always_comb begin
      sample_bin[WIDTH-1] = gray_i[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         sample_bin[i] = sample_bin[i+1] ^ gray_i[i];
      end
   end

   // Modulo-2^WIDTH distance from the last accepted value; the subtraction
   // wraps naturally at WIDTH bits, so 0 -> all-ones reads as a backward step.
   assign delta = sample_bin - bin_q;

   always_comb begin
      // NOTE: every variable gets its hold/idle value first, so no path through
      // the branches below can leave one unassigned and infer a latch.
      state_d = state_q;
      bin_d   = bin_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      total_d = total_q;
      error_d = error_q;

      if (clear_i) begin
         // Clear restarts tracking; a sample in the same cycle is a first sample.
         total_d = '0;
         error_d = 1'b0;
         if (valid_i) begin
            bin_d   = sample_bin;
            state_d = TRACK;
         end else begin
            state_d = IDLE;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (valid_i) begin
                  bin_d   = sample_bin;
                  state_d = TRACK;
               end
            end
            TRACK: begin
               if (valid_i) begin
                  if (delta == WIDTH'(1)) begin
                     step_d  = 1'b1;
                     wrap_d  = (bin_q == '1);
                     total_d = total_q + ACC_WIDTH'(1);
                     bin_d   = sample_bin;
                  end else if (delta != '0) begin
                     // Illegal jump: flag it and resync to the new value.
                     error_d = 1'b1;
                     bin_d   = sample_bin;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset_i) begin
         state_q <= IDLE;
         bin_q   <= '0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
         total_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
         total_q <= total_d;
         error_q <= error_d;
      end
   end

   assign bin_o    = bin_q;
   assign step_o   = step_q;
   assign wrap_o   = wrap_q;
   assign total_o  = total_q;
   assign error_o  = error_q;
   assign locked_o = (state_q == TRACK);

endmodule

// File: tb/tb_gray_counter_decoder.sv
// ---------------------------------------------------------------------------
// tb_gray_counter_decoder
//
// Purpose:
//   Self-checking bench for gray_counter_decoder (WIDTH=3, ACC_WIDTH=8).
//   A behavioural model tracks the expected outputs as plain integers. A
//   negedge process compares every output against it on every cycle after
//   the first reset. Directed sequences also check hand-computed literals.
// ---------------------------------------------------------------------------
module tb_gray_counter_decoder;

   localparam int W   = 3;
   localparam int AW  = 8;
   localparam int MOD = 1 << W;
   localparam int AMOD = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          valid = 1'b0;
   logic [W-1:0]  gray = '0;
   logic          clear = 1'b0;
   logic [W-1:0]  bin_o;
   logic          step_o;
   logic          wrap_o;
   logic [AW-1:0] total_o;
   logic          error_o;
   logic          locked_o;

   int total_checks = 0;
   int bad_checks   = 0;
   bit run          = 1'b0;
   int n_step       = 0;
   int n_wrap       = 0;

   // Model state, all plain integers.
   int m_bin = 0, m_total = 0;
   bit m_step = 0, m_wrap = 0, m_err = 0, m_locked = 0;

   gray_counter_decoder #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .valid_i (valid),
      .gray_i  (gray),
      .clear_i (clear),
      .bin_o   (bin_o),
      .step_o  (step_o),
      .wrap_o  (wrap_o),
      .total_o (total_o),
      .error_o (error_o),
      .locked_o(locked_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Gray code of n is n ^ (n >> 1); invert by searching all codes.
   function automatic int gray_of(input int n);
      return n ^ (n >> 1);
   endfunction

   function automatic int bin_of(input int g);
      for (int n = 0; n < MOD; n++) begin
         if (gray_of(n) == g) return n;
      end
      return -1;
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      total_checks++;
      if (actual !== expected) begin
         bad_checks++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: applies the documented rules to the inputs seen at each edge.
   always @(posedge clk) begin
      int nb, d;
      if (reset) begin
         m_bin = 0; m_total = 0; m_step = 0; m_wrap = 0; m_err = 0; m_locked = 0;
      end else begin
         m_step = 0;
         m_wrap = 0;
         if (clear) begin
            m_total = 0;
            m_err   = 0;
            if (valid) begin
               m_bin    = bin_of(int'(gray));
               m_locked = 1;
            end else begin
               m_locked = 0;
            end
         end else if (valid) begin
            nb = bin_of(int'(gray));
            if (!m_locked) begin
               m_bin    = nb;
               m_locked = 1;
            end else begin
               d = (nb - m_bin + MOD) % MOD;
               if (d == 1) begin
                  m_step  = 1;
                  m_wrap  = (m_bin == MOD - 1);
                  m_total = (m_total + 1) % AMOD;
                  m_bin   = nb;
               end else if (d != 0) begin
                  m_err = 1;
                  m_bin = nb;
               end
            end
         end
      end
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      if (run) begin
         check("bin_o",    int'(bin_o),    m_bin);
         check("step_o",   int'(step_o),   int'(m_step));
         check("wrap_o",   int'(wrap_o),   int'(m_wrap));
         check("total_o",  int'(total_o),  m_total);
         check("error_o",  int'(error_o),  int'(m_err));
         check("locked_o", int'(locked_o), int'(m_locked));
         if (step_o === 1'b1) n_step++;
         if (wrap_o === 1'b1) n_wrap++;
      end
   end

   // One cycle of stimulus; returns just after the edge that consumed it.
   task automatic cyc(input bit r, input bit v, input int g, input bit c);
      @(negedge clk);
      reset = r;
      valid = v;
      gray  = W'(g);
      clear = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int s0, w0;

      // Reset, then pin the reset state.
      cyc(1, 0, 0, 0);
      run = 1'b1;
      check("reset_bin",    int'(bin_o), 0);
      check("reset_total",  int'(total_o), 0);
      check("reset_locked", int'(locked_o), 0);
      check("reset_error",  int'(error_o), 0);

      // Full gray cycle 000..100 then 000: lock plus eight legal steps.
      s0 = n_step; w0 = n_wrap;
      cyc(0, 1, 'b000, 0);
      check("lock_bin", int'(bin_o), 0);
      check("lock_locked", int'(locked_o), 1);
      check("lock_step", int'(step_o), 0);
      cyc(0, 1, 'b001, 0);
      check("first_step", int'(step_o), 1);
      check("first_bin", int'(bin_o), 1);
      cyc(0, 1, 'b011, 0);
      cyc(0, 1, 'b010, 0);
      cyc(0, 1, 'b110, 0);
      cyc(0, 1, 'b111, 0);
      cyc(0, 1, 'b101, 0);
      cyc(0, 1, 'b100, 0);
      check("seq_bin7", int'(bin_o), 7);
      cyc(0, 1, 'b000, 0);
      check("seq_wrap", int'(wrap_o), 1);
      check("seq_bin0", int'(bin_o), 0);
      cyc(0, 0, 0, 0);
      check("seq_total", int'(total_o), 8);
      check("model_total", m_total, 8);
      check("seq_steps", n_step - s0, 8);
      check("seq_wraps", n_wrap - w0, 1);
      check("idle_step", int'(step_o), 0);
      check("idle_wrap", int'(wrap_o), 0);

      // Lock at 011 and repeat it, with idle cycles in between.
      s0 = n_step;
      cyc(0, 1, 'b011, 1);
      check("rep_lock_bin", int'(bin_o), 2);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 'b011, 0);
         cyc(0, 0, 'b111, 0);
      end
      check("rep_steps", n_step - s0, 0);
      check("rep_total", int'(total_o), 0);
      check("rep_error", int'(error_o), 0);
      check("rep_bin", int'(bin_o), 2);

      // Skip forward: 0 -> 2 is an error; 2 -> 4 is still an error; 4 -> 5 steps.
      cyc(0, 1, 'b000, 1);
      cyc(0, 1, 'b011, 0);
      check("skip_error", int'(error_o), 1);
      check("skip_bin", int'(bin_o), 2);
      check("skip_total", int'(total_o), 0);
      cyc(0, 1, 'b110, 0);
      check("skip2_error", int'(error_o), 1);
      check("skip2_step", int'(step_o), 0);
      check("skip2_bin", int'(bin_o), 4);
      cyc(0, 1, 'b111, 0);
      check("resync_step", int'(step_o), 1);
      check("resync_total", int'(total_o), 1);
      check("sticky_error", int'(error_o), 1);

      // Backward step 2 -> 1.
      cyc(0, 1, 'b011, 1);
      check("clear_error", int'(error_o), 0);
      cyc(0, 1, 'b001, 0);
      check("back_error", int'(error_o), 1);
      check("back_step", int'(step_o), 0);
      check("back_bin", int'(bin_o), 1);

      // 300 legal steps from 0: total wraps to 44, wrap_o fires 37 times.
      cyc(0, 1, 'b000, 1);
      s0 = n_step; w0 = n_wrap;
      for (int i = 1; i <= 300; i++) begin
         cyc(0, 1, gray_of(i % MOD), 0);
      end
      cyc(0, 0, 0, 0);
      check("long_total", int'(total_o), 44);
      check("model_long_total", m_total, 44);
      check("long_steps", n_step - s0, 300);
      check("long_wraps", n_wrap - w0, 37);
      check("long_bin", int'(bin_o), 4);
      check("long_error", int'(error_o), 0);

      // Reset mid-sequence overrides a valid sample.
      cyc(0, 1, 'b110, 0);
      cyc(1, 1, 'b111, 0);
      check("midreset_bin", int'(bin_o), 0);
      check("midreset_total", int'(total_o), 0);
      check("midreset_locked", int'(locked_o), 0);
      check("midreset_step", int'(step_o), 0);

      // Clear with a valid sample loads it as a first sample.
      cyc(0, 1, 'b000, 0);
      cyc(0, 1, 'b011, 0);
      cyc(0, 1, 'b010, 1);
      check("clear_total", int'(total_o), 0);
      check("clear_err", int'(error_o), 0);
      check("clear_bin", int'(bin_o), 3);
      check("clear_locked", int'(locked_o), 1);
      check("clear_step", int'(step_o), 0);

      // Clear with no sample drops lock and holds bin_o.
      cyc(0, 0, 0, 1);
      check("clear_idle_locked", int'(locked_o), 0);
      check("clear_idle_bin", int'(bin_o), 3);
      cyc(0, 0, 0, 0);

      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
